// File: rtl/ohc7_pkg.sv
// Shared definitions for the one-hot mod-7 residue datapath: code width,
// residue constants and reference helpers for code checking and addition.
package ohc7_pkg;

    localparam int OHC_W = 7;

    localparam logic [6:0] R0 = 7'b0000001;
    localparam logic [6:0] R1 = 7'b0000010;
    localparam logic [6:0] R2 = 7'b0000100;
    localparam logic [6:0] R3 = 7'b0001000;
    localparam logic [6:0] R4 = 7'b0010000;
    localparam logic [6:0] R5 = 7'b0100000;
    localparam logic [6:0] R6 = 7'b1000000;

    function automatic logic onehot_ok(input logic [6:0] code);
        return (code != 7'b0000000) && ((code & (code - 7'b0000001)) == 7'b0000000);
    endfunction

    // Each set bit of a selects b rotated left by its index: the AND/OR pair terms.
    function automatic logic [6:0] ohc7_add(input logic [6:0] a, input logic [6:0] b);
        logic [6:0]  sum;
        logic [13:0] rot;
        sum = 7'b0000000;
        for (int i = 0; i < 7; i++) begin
            rot = {b, b} << i;
            sum = sum | (rot[13:7] & {7{a[i]}});
        end
        return sum;
    endfunction

endpackage

// File: rtl/ohc7_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: grant is a pure function of req and the pointer;
// the pointer moves past the granted requester only when advance is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0] N_C = (PW+1)'(N);

    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  w_off;
    logic [PW-1:0]  w_gidx;
    logic [PW:0]    w_sum;
    logic [PW:0]    w_diff;
    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    logic           w_any;

    // Rotate requests so the pointer sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        w_req2 = {req, req} >> r_ptr;
        w_rot  = w_req2[N-1:0];
        w_off  = '0;
        w_any  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_off = w_rot[k] ? PW'(k) : w_off;
            w_any = w_any | w_rot[k];
        end
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_diff = w_sum - N_C;
        w_gidx = (w_sum >= N_C) ? w_diff[PW-1:0] : w_sum[PW-1:0];
        grant  = w_any ? ({{(N-1){1'b0}}, 1'b1} << w_gidx) : '0;
    end

    // Pointer register: next search starts just after the accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/ohc_7_modulo_adder.sv
// Combinational one-hot mod-7 adder: sum bit k is the OR of a[i]&b[(k-i) mod 7].
module ohc_7_modulo_adder (
    input  logic [6:0] i_a,
    input  logic [6:0] i_b,
    output logic [6:0] o_sum
);

    for (genvar k = 0; k < 7; k++) begin : g_res
        logic [6:0] w_terms;
        for (genvar i = 0; i < 7; i++) begin : g_pair
            assign w_terms[i] = i_a[i] & i_b[(k - i + 7) % 7];
        end
        assign o_sum[k] = |w_terms;
    end

endmodule

// File: rtl/ohc7_add_scheduler.sv
// Shares one OHC mod-7 adder among N_REQ requesters: round-robin accept into S1,
// add between S1 and the S2 output register, with saturating op/error counters.
module ohc7_add_scheduler
    import ohc7_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [7*N_REQ-1:0]   req_a,
    input  logic [7*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [6:0]           res_sum,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_err,
    output logic [CNT_W-1:0]     cnt_ops,
    output logic [CNT_W-1:0]     cnt_err
);

    logic             r_s1_valid;
    logic [6:0]       r_s1_a;
    logic [6:0]       r_s1_b;
    logic [ID_W-1:0]  r_s1_id;

    logic             w_s2_en;
    logic             w_s1_en;
    logic             w_hs;
    logic             w_s1_err;
    logic [N_REQ-1:0] w_grant;
    logic [6:0]       w_sel_a;
    logic [6:0]       w_sel_b;
    logic [ID_W-1:0]  w_sel_id;
    logic [6:0]       w_add_sum;

    assign w_s2_en = !res_valid || res_ready;
    assign w_s1_en = !r_s1_valid || w_s2_en;
    // res_ready reaches req_ready combinationally through s2_en/s1_en.
    assign req_ready = w_grant & {N_REQ{w_s1_en & rst_n}};
    assign w_hs      = |(req_valid & req_ready);
    assign w_s1_err  = !(onehot_ok(r_s1_a) && onehot_ok(r_s1_b));

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (w_hs),
        .grant   (w_grant)
    );

    // Operand and ID mux driven by the one-hot grant.
    always_comb begin
        w_sel_a  = 7'b0000000;
        w_sel_b  = 7'b0000000;
        w_sel_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sel_a  = w_sel_a  | (req_a[7*i +: 7] & {7{w_grant[i]}});
            w_sel_b  = w_sel_b  | (req_b[7*i +: 7] & {7{w_grant[i]}});
            w_sel_id = w_sel_id | (ID_W'(i) & {ID_W{w_grant[i]}});
        end
    end

    ohc_7_modulo_adder u_add (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_sum (w_add_sum)
    );

    // Stage 1: captures the accepted operand pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= 7'b0000000;
            r_s1_b     <= 7'b0000000;
            r_s1_id    <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_s1_a  <= w_sel_a;
                r_s1_b  <= w_sel_b;
                r_s1_id <= w_sel_id;
            end else begin
                r_s1_a  <= r_s1_a;
                r_s1_b  <= r_s1_b;
                r_s1_id <= r_s1_id;
            end
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage 2: output register; data held when an empty slot moves through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= 7'b0000000;
            res_id    <= '0;
            res_err   <= 1'b0;
        end else if (w_s2_en) begin
            res_valid <= r_s1_valid;
            if (r_s1_valid) begin
                res_sum <= w_s1_err ? 7'b0000000 : w_add_sum;
                res_id  <= r_s1_id;
                res_err <= w_s1_err;
            end else begin
                res_sum <= res_sum;
                res_id  <= res_id;
                res_err <= res_err;
            end
        end else begin
            res_valid <= res_valid;
        end
    end

    // Saturating statistics on each output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ops <= '0;
            cnt_err <= '0;
        end else if (res_valid && res_ready) begin
            cnt_ops <= (cnt_ops != {CNT_W{1'b1}}) ? cnt_ops + 1'b1 : cnt_ops;
            cnt_err <= (res_err && (cnt_err != {CNT_W{1'b1}})) ? cnt_err + 1'b1 : cnt_err;
        end else begin
            cnt_ops <= cnt_ops;
            cnt_err <= cnt_err;
        end
    end

endmodule

// File: tb/tb_ohc7_add_scheduler.sv
// Directed-vector bench for ohc7_add_scheduler with hand-computed expectations.
module tb_ohc7_add_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [27:0] req_a;
    logic [27:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [6:0]  res_sum;
    logic [1:0]  res_id;
    logic        res_err;
    logic [15:0] cnt_ops;
    logic [15:0] cnt_err;

    int n_cmp = 0;
    int n_mis = 0;

    ohc7_add_scheduler #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_err   (res_err),
        .cnt_ops   (cnt_ops),
        .cnt_err   (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ohc(input int v);
        logic [6:0] r;
        r = 7'b0000000;
        r[v] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        res_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One isolated operation with res_ready high; counters settled on return.
    task automatic do_op(input int idx, input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] exp_sum, input logic exp_err);
        req_valid = 4'b0000;
        req_valid[idx] = 1'b1;
        req_a[7*idx +: 7] = a;
        req_b[7*idx +: 7] = b;
        res_ready = 1'b1;
        #1;
        chk_eq("op_ready", req_ready, 32'(ohc(idx)));
        tick();
        req_valid = 4'b0000;
        tick();
        chk_eq("op_valid", res_valid, 1'b1);
        chk_eq("op_sum", res_sum, exp_sum);
        chk_eq("op_id", res_id, idx);
        chk_eq("op_err", res_err, exp_err);
        tick();
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_a     = 28'h0;
        req_b     = 28'h0;
        res_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_eq("rst_valid", res_valid, 1'b0);
        chk_eq("rst_sum", res_sum, 7'b0000000);
        chk_eq("rst_id", res_id, 2'd0);
        chk_eq("rst_err", res_err, 1'b0);
        chk_eq("rst_cnt_ops", cnt_ops, 16'd0);
        chk_eq("rst_cnt_err", cnt_err, 16'd0);
        chk_eq("rst_ready", req_ready, 4'b0000);
        tick();
        chk_eq("rst_ready_clk", req_ready, 4'b0000);
        rst_n = 1'b1;
        req_valid = 4'b0000;
        tick();

        // Single op and wrap-around sum.
        do_op(0, 7'b0000100, 7'b0010000, 7'b1000000, 1'b0);
        chk_eq("cnt_single", cnt_ops, 16'd1);
        do_op(0, 7'b0100000, 7'b0010000, 7'b0000100, 1'b0);
        chk_eq("cnt_wrap", cnt_ops, 16'd2);

        // Exhaustive 7x7 sweep on requester 2.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7; j++) begin
                do_op(2, ohc(i), ohc(j), ohc((i + j) % 7), 1'b0);
            end
        end
        chk_eq("cnt_sweep", cnt_ops, 16'd51);

        // Malformed codes.
        do_op(1, 7'b0000011, 7'b0000010, 7'b0000000, 1'b1);
        chk_eq("cnt_err_1", cnt_err, 16'd1);
        do_op(3, 7'b0000000, 7'b0001000, 7'b0000000, 1'b1);
        chk_eq("cnt_err_2", cnt_err, 16'd2);
        chk_eq("cnt_ops_mal", cnt_ops, 16'd53);

        // Reset with S1 and S2 both full.
        res_ready = 1'b0;
        req_a[6:0]  = 7'b0000010;
        req_b[6:0]  = 7'b0000010;
        req_a[13:7] = 7'b0000010;
        req_b[13:7] = 7'b0000010;
        req_valid = 4'b0011;
        tick();
        tick();
        chk_eq("full_valid", res_valid, 1'b1);
        chk_eq("full_ready", req_ready, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_valid", res_valid, 1'b0);
        chk_eq("arst_cnt_ops", cnt_ops, 16'd0);
        chk_eq("arst_cnt_err", cnt_err, 16'd0);
        chk_eq("arst_ready", req_ready, 4'b0000);
        req_valid = 4'b1010;
        rst_n = 1'b1;
        #1;
        chk_eq("arst_first_grant", req_ready, 4'b0010);
        req_valid = 4'b0000;
        tick();

        // Contention: all four valid for 8 cycles.
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[7*i +: 7] = ohc(i);
            req_b[7*i +: 7] = ohc(1);
        end
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) chk_eq("rr_grant", req_ready, 32'(ohc(c % 4)));
            if (c >= 2) begin
                chk_eq("rr_res_valid", res_valid, 1'b1);
                chk_eq("rr_res_id", res_id, (c - 2) % 4);
                chk_eq("rr_res_sum", res_sum, 32'(ohc(((c - 2) % 4) + 1)));
            end
            tick();
        end
        chk_eq("rr_drained", res_valid, 1'b0);
        chk_eq("rr_cnt", cnt_ops, 16'd8);

        // Backpressure: two ops in flight, outputs frozen, then ordered drain.
        do_reset();
        req_a[6:0]  = 7'b0000010;
        req_b[6:0]  = 7'b0000010;
        req_a[13:7] = 7'b0001000;
        req_b[13:7] = 7'b0000100;
        req_valid = 4'b0011;
        #1;
        chk_eq("bp_grant0", req_ready, 4'b0001);
        tick();
        chk_eq("bp_grant1", req_ready, 4'b0010);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk_eq("bp_ready", req_ready, 4'b0000);
            chk_eq("bp_valid", res_valid, 1'b1);
            chk_eq("bp_sum", res_sum, 7'b0000100);
            chk_eq("bp_id", res_id, 2'd0);
            tick();
        end
        req_valid = 4'b0000;
        res_ready = 1'b1;
        #1;
        chk_eq("drain0_valid", res_valid, 1'b1);
        chk_eq("drain0_id", res_id, 2'd0);
        tick();
        chk_eq("drain1_valid", res_valid, 1'b1);
        chk_eq("drain1_id", res_id, 2'd1);
        chk_eq("drain1_sum", res_sum, 7'b0100000);
        tick();
        chk_eq("drain_empty", res_valid, 1'b0);
        chk_eq("drain_cnt", cnt_ops, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
